// File: rtl/score_digit_splitter.sv
// score_digit_splitter
// Converts an unsigned binary score (0..MAX_VAL) into a tens value and a
// units value by repeated subtraction of ten. This block feeds the two-digit
// 7-segment converter.
//
// While no result exists, and while a conversion is running, the outputs
// carry the pending code PEND_TENS/PEND_UNITS. The converter displays that
// code as "--".
//
// Optional feature, selected by the macro SCORE_CLAMP_EN:
//   defined   - a score above MAX_VAL is clamped to MAX_VAL at capture.
//   undefined - a score above MAX_VAL is rejected. The block stays idle and
//               its outputs return to the pending code.
module score_digit_splitter #(
    parameter int SCORE_W    = 7,
    parameter int MAX_VAL    = 100,
    parameter int PEND_TENS  = 25,
    parameter int PEND_UNITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    input  logic               clear,
    output logic               busy,
    output logic               done,
    output logic [4:0]         Tens,
    output logic [3:0]         Units
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [SCORE_W-1:0] MAX_V   = SCORE_W'(MAX_VAL);
    localparam logic [SCORE_W-1:0] TEN_V   = SCORE_W'(10);
    localparam logic [4:0]         P_TENS  = 5'(PEND_TENS);
    localparam logic [3:0]         P_UNITS = 4'(PEND_UNITS);
    localparam logic [4:0]         TCNT_MAX = 5'd31;

    logic [1:0]         r_state;
    logic [SCORE_W-1:0] r_rem;
    logic [4:0]         r_tcnt;
    logic               r_busy;
    logic               r_done;
    logic [4:0]         r_tens;
    logic [3:0]         r_units;

    logic               w_over;
    logic               w_accept;
    logic [SCORE_W-1:0] w_load;

    // Decide how an out-of-range score is treated at capture time.
    always_comb begin
        w_over = (score > MAX_V);
`ifdef SCORE_CLAMP_EN
        w_accept = 1'b1;
        w_load   = w_over ? MAX_V : score;
`else
        w_accept = !w_over;
        w_load   = score;
`endif
    end

    // Run the capture / subtract-by-ten / publish sequence.
    // Clear takes priority over every other action.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_tcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tens  <= P_TENS;
            r_units <= P_UNITS;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tens  <= P_TENS;
            r_units <= P_UNITS;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (score_valid) begin
                        // Accepted or rejected, the display goes back to "--".
                        r_tens  <= P_TENS;
                        r_units <= P_UNITS;
                        if (w_accept) begin
                            r_rem   <= w_load;
                            r_tcnt  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (r_rem >= TEN_V) begin
                        r_rem  <= r_rem - TEN_V;
                        r_tcnt <= (r_tcnt == TCNT_MAX) ? TCNT_MAX : r_tcnt + 5'd1;
                    end else begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    // The remainder is below ten here, so the low nibble is the
                    // complete units digit.
                    r_tens  <= r_tcnt;
                    r_units <= r_rem[3:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign Tens  = r_tens;
    assign Units = r_units;

endmodule
